// File: rtl/pipe_stage_reg.sv
// Purpose: inter-stage pipeline register with a 2-entry skid buffer, flush, and stall/flush perf counters.
// Latency: 1 cycle from accepted input to OUT_VALID; full throughput of 1 entry/cycle when downstream is ready.
// Backpressure: IN_READY is a flop (low only when the skid holds an entry); nothing is dropped or duplicated.
module pipe_stage_reg #(
    parameter int PC_WIDTH      = 32,
    parameter int PAYLOAD_WIDTH = 128,
    parameter int CNT_WIDTH     = 16,
    parameter bit ZERO_ON_KILL  = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [PC_WIDTH-1:0]      IN_PC,
    input  logic [PAYLOAD_WIDTH-1:0] IN_PAYLOAD,
    input  logic                     IN_RD_WE,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [PC_WIDTH-1:0]      OUT_PC,
    output logic [PAYLOAD_WIDTH-1:0] OUT_PAYLOAD,
    output logic                     OUT_RD_WE,
    output logic [CNT_WIDTH-1:0]     STALL_COUNT,
    output logic [CNT_WIDTH-1:0]     FLUSH_COUNT
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]      pc;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic                     rd_we;
    } entry_t;

    // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               state;
    entry_t               main_q;
    entry_t               skid_q;
    entry_t               in_ent;
    logic                 out_vld_q;
    logic                 in_rdy_q;
    logic                 accept;
    logic                 drain;
    logic                 stall_hit;
    logic                 flush_hit;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    assign in_ent = '{pc: IN_PC, payload: IN_PAYLOAD, rd_we: IN_RD_WE};
    assign accept = IN_VALID & in_rdy_q;
    assign drain  = out_vld_q & OUT_READY;

    // Handshake FSM and entry storage; valid and ready are kept as flops alongside the state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_EMPTY;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (FLUSH) begin
            // Flush wins over accept/drain: the offered input is dropped, held entries are killed
            state        <= S_EMPTY;
            out_vld_q    <= 1'b0;
            in_rdy_q     <= 1'b1;
            main_q.rd_we <= 1'b0;
            skid_q.rd_we <= 1'b0;
            if (ZERO_ON_KILL) begin
                main_q.pc      <= '0;
                main_q.payload <= '0;
                skid_q.pc      <= '0;
                skid_q.payload <= '0;
            end
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_q    <= in_ent;
                        state     <= S_ONE;
                        out_vld_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        main_q <= in_ent;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind main and close the input
                        skid_q   <= in_ent;
                        state    <= S_FULL;
                        in_rdy_q <= 1'b0;
                    end else if (drain) begin
                        state     <= S_EMPTY;
                        out_vld_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    // Input is closed here, so the skid can only move forward, never be overwritten
                    if (drain) begin
                        main_q   <= skid_q;
                        state    <= S_ONE;
                        in_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

    // A flush only counts when it actually kills something: a held entry or a valid input
    assign stall_hit = out_vld_q & ~OUT_READY;
    assign flush_hit = FLUSH & (out_vld_q | IN_VALID);

    // Saturating performance counters; cleared by reset only, never by flush
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_hit && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_hit && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign IN_READY    = in_rdy_q;
    assign OUT_VALID   = out_vld_q;
    assign OUT_PC      = main_q.pc;
    assign OUT_PAYLOAD = main_q.payload;
    assign OUT_RD_WE   = main_q.rd_we & out_vld_q;
    assign STALL_COUNT = stall_cnt_q;
    assign FLUSH_COUNT = flush_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed decode→execute register with stall/clear.
- Replaces bare stall/clear with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Adds a synchronous flush that kills in-flight entries, plus saturating stall/flush performance counters.
- Instantiated between any two core stages: IF/ID, ID/EX, EX/MEM.

Parameters:
- PC_WIDTH, 32, width of PC field.
- PAYLOAD_WIDTH, 128, width of opaque control/data payload (rs/rd addresses, operands, imm, control bits).
- CNT_WIDTH, 16, width of each performance counter.
- ZERO_ON_KILL, 1, 1 = PC/payload of killed or reset entries forced to 0; 0 = data fields held, only valid/write-enable cleared.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous kill of all held entries and the current input.
- IN_VALID  in  1  upstream entry valid.
- IN_READY  out  1  stage can accept an entry this cycle.
- IN_PC  in  PC_WIDTH  upstream PC.
- IN_PAYLOAD  in  PAYLOAD_WIDTH  upstream payload.
- IN_RD_WE  in  1  upstream register-file write enable.
- OUT_VALID  out  1  downstream entry valid.
- OUT_READY  in  1  downstream accepts entry.
- OUT_PC  out  PC_WIDTH  held PC.
- OUT_PAYLOAD  out  PAYLOAD_WIDTH  held payload.
- OUT_RD_WE  out  1  held write enable, always ANDed with OUT_VALID.
- STALL_COUNT  out  CNT_WIDTH  cycles with OUT_VALID=1 and OUT_READY=0.
- FLUSH_COUNT  out  CNT_WIDTH  cycles in which FLUSH killed at least one valid entry (held or input).

Behaviour:
- Storage: main entry (drives OUT_*) and skid entry. Each holds pc, payload, rd_we and valid.
- States: EMPTY (no valid entry), ONE (main valid), FULL (main + skid valid).
- IN_READY = !skid_valid. It is registered, with no combinational path from OUT_READY.
- Accept = IN_VALID & IN_READY. Drain = OUT_VALID & OUT_READY.
- EMPTY: accept → ONE, input loads into main. OUT_VALID rises the next cycle (latency 1).
- ONE:
  - accept & drain → ONE, main reloads from input (full throughput, 1 entry/cycle).
  - accept & !drain → FULL, input loads into skid.
  - !accept & drain → EMPTY.
  - otherwise hold.
- FULL (IN_READY=0):
  - drain → ONE, skid moves into main.
  - else hold.
- No input is accepted in FULL, so the skid is never overwritten.
- Order is strictly FIFO. An entry never appears twice at the output.
- OUT_* stay stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH=1 has priority over accept and drain:
  - next cycle the state is EMPTY, OUT_VALID=0, IN_READY=1;
  - the input offered in the flush cycle is dropped;
  - a drain in the flush cycle still counts as consumed downstream;
  - with ZERO_ON_KILL=1, main/skid pc and payload are zeroed.
- Reset (RST_N low, asynchronous, any time including mid-FULL): state EMPTY, IN_READY=1, OUT_VALID=0, OUT_RD_WE=0, OUT_PC=0, OUT_PAYLOAD=0, both counters 0. The first edge after release behaves as EMPTY.
- Counters:
  - each increments by 1 per qualifying cycle and saturates at 2^CNT_WIDTH-1 (no wrap);
  - STALL_COUNT counts in the flush cycle if its condition holds;
  - FLUSH does not reset the counters; only RST_N does.
- IN_VALID=0 leaves held entries unchanged. Inputs are don't-care when IN_VALID=0.

Test Plan:
- Reset then stream PCs 0x00,0x04,0x08,0x0C with IN_VALID=1 and OUT_READY=1 → OUT_PC matches each value one cycle later, back-to-back; IN_READY stays 1; STALL_COUNT=0.
- Send 0x10 and 0x14 with OUT_READY=0 → state FULL, IN_READY=0; 0x18 is held upstream; OUT_PC holds 0x10 for 3 stall cycles; STALL_COUNT=3. Raise OUT_READY → outputs 0x10, 0x14, 0x18 in order, no loss or duplicate.
- In FULL (0x20 main, 0x24 skid), assert FLUSH with IN_VALID=1 on 0x28 → next cycle OUT_VALID=0, OUT_RD_WE=0, IN_READY=1, OUT_PC=0 (ZERO_ON_KILL=1); 0x28 never appears; FLUSH_COUNT=1.
- FLUSH while EMPTY and IN_VALID=0 → no state change, FLUSH_COUNT unchanged.
- Drop RST_N asynchronously mid-FULL (between edges) → outputs zero immediately; after release, 0x40 is accepted and appears 1 cycle later.
- CNT_WIDTH=4, hold a stall for 20 cycles → STALL_COUNT saturates at 15.
